vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  - Source end of the pixel-stream timing interface consumed by the drawing stages
//    (hcount/vcount/hsync/vsync/hblnk/vblnk bus).
//  - Free-running horizontal/vertical counters for 1024x768@60 (65 MHz pixel clock).
//  - Decodes sync and blank windows; drives the first stage of the draw pipeline.
// PARAMETERS
//  H_VISIBLE  1024  active pixels per line
//  H_FP       24    horizontal front porch (pixels)
//  H_SYNC     136   horizontal sync width (pixels)
//  H_BP       160   horizontal back porch (pixels); H_TOTAL = sum = 1344
//  V_VISIBLE  768   active lines per frame
//  V_FP       3     vertical front porch (lines)
//  V_SYNC     6     vertical sync width (lines)
//  V_BP       29    vertical back porch (lines); V_TOTAL = sum = 806
// PORTS
//  clk_in             in   1   pixel clock
//  rst                in   1   asynchronous reset, active-high
//  en_in              in   1   advance enable; counters hold when low
//  hcount_out         out  12  horizontal position, 0..H_TOTAL-1
//  hsync_out          out  1   horizontal sync, active-high
//  hblnk_out          out  1   horizontal blank, high outside visible area
//  vcount_out         out  12  vertical position, 0..V_TOTAL-1
//  vsync_out          out  1   vertical sync, active-high
//  vblnk_out          out  1   vertical blank, high outside visible area
//  frame_start_out    out  1   (VGA_FRAME_START_EN only) start-of-frame pulse
// BEHAVIOUR
//  - Reset (async assert; deassert sampled on clk_in): all outputs 0, i.e. position (0,0),
//    visible, no sync. First rising edge with en_in=1 after reset moves to (1,0).
//  - All outputs are registered. Sync/blank flags are decoded from the next counter
//    values, so every flag is coherent with the counts on the same cycle; zero skew.
//  - Horizontal: hcount_nxt = (hcount == H_TOTAL-1) ? 0 : hcount+1.
//  - Vertical: vcount advances only on a line wrap (hcount H_TOTAL-1 -> 0);
//    vcount_nxt = (vcount == V_TOTAL-1) ? 0 : vcount+1. Frame wrap: (1343,805) -> (0,0).
//  - hblnk_out = hcount >= H_VISIBLE (1024..1343).
//  - hsync_out = hcount in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] = [1048,1183].
//  - vblnk_out = vcount >= V_VISIBLE (768..805); covers the full line, all hcount.
//  - vsync_out = vcount in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1] = [771,776].
//  - en_in=0: all registers hold their value, including flags and pulse.
//    The stream does not skip or repeat positions when enable resumes.
//  - Comparisons are unsigned 12-bit; parameter sums must be <= 4095.
//  - Counters never exceed TOTAL-1. An out-of-range value, which can only arise from an
//    upset, wraps to 0 on the next enabled cycle (>= compare, not ==).
//  - Reset mid-line or mid-frame returns to (0,0) immediately, with no pending pulse.
// CONFIGURATION
//  - VGA_FRAME_START_EN defined:
//    - frame_start_out is present.
//    - Registered; high for exactly one enabled cycle, when outputs show (0,0) after a
//      frame wrap. It does not fire on the post-reset (0,0).
//    - Reset value 0.
//  - VGA_FRAME_START_EN undefined:
//    - Port and logic absent; all other behaviour identical.
// TESTING
//  - rst pulse at (500,300) -> outputs 0 asynchronously; next en cycle gives hcount=1,
//    vcount=0.
//  - Run to hcount=1343, vcount=10 -> next cycle hcount=0, vcount=11; vcount is steady
//    for all 1344 cycles of the line.
//  - hsync edges: hcount 1047 -> hsync 0; 1048 -> 1; 1183 -> 1; 1184 -> 0.
//    hblnk is 0 at 1023 and 1 at 1024.
//  - Vertical: vblnk 0 at vcount 767, 1 at 768; vsync 1 exactly for vcount 771..776.
//    Frame wrap (1343,805) -> (0,0) with blanks 0.
//  - Frame period: 1344*806 = 1083264 enabled cycles between repeats of (0,0).
//    With VGA_FRAME_START_EN, frame_start_out pulses once per frame and never after reset.
//  - en_in low for 7 cycles at (1047,771) -> all outputs frozen; on release the next
//    output is (1048,771) with hsync=1, vsync=1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Free-running 1024x768@60 pixel timing source: registered h/v counters with sync and blank flags.
// Optional start-of-frame pulse output enabled by defining VGA_FRAME_START_EN.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 1024,
  parameter int unsigned H_FP      = 24,
  parameter int unsigned H_SYNC    = 136,
  parameter int unsigned H_BP      = 160,
  parameter int unsigned V_VISIBLE = 768,
  parameter int unsigned V_FP      = 3,
  parameter int unsigned V_SYNC    = 6,
  parameter int unsigned V_BP      = 29
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        en_in,
  output logic [11:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [11:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out
`ifdef VGA_FRAME_START_EN
  ,
  output logic        frame_start_out
`endif
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST       = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_VIS        = 12'(H_VISIBLE);
  localparam logic [11:0] H_SYNC_START = 12'(H_VISIBLE + H_FP);
  localparam logic [11:0] H_SYNC_END   = 12'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [11:0] V_LAST       = 12'(V_TOTAL - 1);
  localparam logic [11:0] V_VIS        = 12'(V_VISIBLE);
  localparam logic [11:0] V_SYNC_START = 12'(V_VISIBLE + V_FP);
  localparam logic [11:0] V_SYNC_END   = 12'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic        line_wrap;
  logic [11:0] hcount_nxt;
  logic [11:0] vcount_nxt;
  logic        hsync_nxt;
  logic        hblnk_nxt;
  logic        vsync_nxt;
  logic        vblnk_nxt;

  // Flags are decoded from the next counts so they land in the same cycle as the counts.
  always_comb begin
    line_wrap  = (hcount_out >= H_LAST);
    hcount_nxt = line_wrap ? 12'd0 : hcount_out + 12'd1;
    vcount_nxt = vcount_out;
    if (vcount_out > V_LAST) begin
      vcount_nxt = 12'd0;
    end else if (line_wrap) begin
      vcount_nxt = (vcount_out == V_LAST) ? 12'd0 : vcount_out + 12'd1;
    end
    hblnk_nxt = (hcount_nxt >= H_VIS);
    hsync_nxt = (hcount_nxt >= H_SYNC_START) && (hcount_nxt <= H_SYNC_END);
    vblnk_nxt = (vcount_nxt >= V_VIS);
    vsync_nxt = (vcount_nxt >= V_SYNC_START) && (vcount_nxt <= V_SYNC_END);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      hcount_out <= 12'd0;
      vcount_out <= 12'd0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
    end else if (en_in) begin
      hcount_out <= hcount_nxt;
      vcount_out <= vcount_nxt;
      hsync_out  <= hsync_nxt;
      hblnk_out  <= hblnk_nxt;
      vsync_out  <= vsync_nxt;
      vblnk_out  <= vblnk_nxt;
    end
  end

`ifdef VGA_FRAME_START_EN
  logic frame_start_nxt;

  // Only a genuine wrap from the last line fires; the post-reset (0,0) does not.
  always_comb begin
    frame_start_nxt = line_wrap && (vcount_out == V_LAST);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      frame_start_out <= 1'b0;
    end else if (en_in) begin
      frame_start_out <= frame_start_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: instance A uses full 1024x768 timing, instance B a 16-pixel line with full vertical timing.
// B makes whole frames short enough to walk through; define VGA_FRAME_START_EN to cover the frame pulse.
module tb_vga_timing_gen;

  logic        clk;
  logic        rst_a, rst_b;
  logic        en_a, en_b;
  logic [11:0] hcount_a, vcount_a, hcount_b, vcount_b;
  logic        hsync_a, hblnk_a, vsync_a, vblnk_a;
  logic        hsync_b, hblnk_b, vsync_b, vblnk_b;
`ifdef VGA_FRAME_START_EN
  logic        fs_a, fs_b;
`endif

  int total = 0;
  int bad   = 0;

  vga_timing_gen dut_a (
    .clk_in(clk), .rst(rst_a), .en_in(en_a),
    .hcount_out(hcount_a), .hsync_out(hsync_a), .hblnk_out(hblnk_a),
    .vcount_out(vcount_a), .vsync_out(vsync_a), .vblnk_out(vblnk_a)
`ifdef VGA_FRAME_START_EN
    , .frame_start_out(fs_a)
`endif
  );

  vga_timing_gen #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3)) dut_b (
    .clk_in(clk), .rst(rst_b), .en_in(en_b),
    .hcount_out(hcount_b), .hsync_out(hsync_b), .hblnk_out(hblnk_b),
    .vcount_out(vcount_b), .vsync_out(vsync_b), .vblnk_out(vblnk_b)
`ifdef VGA_FRAME_START_EN
    , .frame_start_out(fs_b)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1ns past the edge before sampling.
  task automatic apply_stimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int vcount_dev;
  int cycles;
  int pulses;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
    #12;
    check_output("rst_a_h",     hcount_a, 0);
    check_output("rst_a_v",     vcount_a, 0);
    check_output("rst_a_flags", {hsync_a, hblnk_a, vsync_a, vblnk_a}, 0);
    check_output("rst_b_flags", {hsync_b, hblnk_b, vsync_b, vblnk_b}, 0);
    rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b1;

    // ---- instance A: 1344-pixel lines ----
    apply_stimulus(1);
    check_output("a_first_h", hcount_a, 1);
    check_output("a_first_v", vcount_a, 0);
    apply_stimulus(499);
    check_output("a_h500", hcount_a, 500);
    rst_a = 1'b1;
    #1;
    check_output("a_async_rst_h", hcount_a, 0);
    check_output("a_async_rst_flags", {hsync_a, hblnk_a, vsync_a, vblnk_a}, 0);
    #2 rst_a = 1'b0;
    apply_stimulus(1);
    check_output("a_post_rst_h", hcount_a, 1);
    check_output("a_post_rst_v", vcount_a, 0);

    apply_stimulus(1022);
    check_output("a_h1023",       hcount_a, 1023);
    check_output("a_hblnk_1023",  hblnk_a, 0);
    apply_stimulus(1);
    check_output("a_hblnk_1024",  hblnk_a, 1);
    check_output("a_hsync_1024",  hsync_a, 0);
    apply_stimulus(23);
    check_output("a_h1047",       hcount_a, 1047);
    check_output("a_hsync_1047",  hsync_a, 0);

    en_a = 1'b0;
    apply_stimulus(7);
    check_output("a_frozen_h",     hcount_a, 1047);
    check_output("a_frozen_hsync", hsync_a, 0);
    check_output("a_frozen_hblnk", hblnk_a, 1);
    en_a = 1'b1;
    apply_stimulus(1);
    check_output("a_resume_h",     hcount_a, 1048);
    check_output("a_hsync_1048",   hsync_a, 1);
    apply_stimulus(135);
    check_output("a_h1183",        hcount_a, 1183);
    check_output("a_hsync_1183",   hsync_a, 1);
    apply_stimulus(1);
    check_output("a_hsync_1184",   hsync_a, 0);
    apply_stimulus(159);
    check_output("a_h1343",        hcount_a, 1343);
    check_output("a_v_line0",      vcount_a, 0);
    apply_stimulus(1);
    check_output("a_wrap_h",       hcount_a, 0);
    check_output("a_wrap_v",       vcount_a, 1);
    check_output("a_wrap_hblnk",   hblnk_a, 0);

    apply_stimulus(9 * 1344);
    check_output("a_line10_start", {hcount_a, vcount_a}, {12'd0, 12'd10});
    vcount_dev = 0;
    for (int i = 0; i < 1343; i++) begin
      apply_stimulus(1);
      if (vcount_a !== 12'd10) vcount_dev++;
    end
    check_output("a_h1343_v10",    {hcount_a, vcount_a}, {12'd1343, 12'd10});
    check_output("a_v_steady",     vcount_dev, 0);
    apply_stimulus(1);
    check_output("a_v11_wrap",     {hcount_a, vcount_a}, {12'd0, 12'd11});

    // ---- instance B: 16-pixel lines (vis 8, sync 10..12), full vertical timing ----
    check_output("b_idle_hold", {hcount_b, vcount_b}, 0);
    en_b = 1'b1;
    apply_stimulus(1);
    check_output("b_first", {hcount_b, vcount_b}, {12'd1, 12'd0});
    apply_stimulus(4804);
    check_output("b_5_300", {hcount_b, vcount_b}, {12'd5, 12'd300});
    rst_b = 1'b1;
    #1;
    check_output("b_async_rst", {hcount_b, vcount_b}, 0);
    #2 rst_b = 1'b0;
    apply_stimulus(1);
    check_output("b_post_rst", {hcount_b, vcount_b}, {12'd1, 12'd0});
`ifdef VGA_FRAME_START_EN
    check_output("b_fs_after_rst", fs_b, 0);
`endif

    apply_stimulus(12286);
    check_output("b_15_767",      {hcount_b, vcount_b}, {12'd15, 12'd767});
    check_output("b_vblnk_767",   vblnk_b, 0);
    apply_stimulus(1);
    check_output("b_0_768",       {hcount_b, vcount_b}, {12'd0, 12'd768});
    check_output("b_vblnk_768",   vblnk_b, 1);
    check_output("b_hblnk_768",   hblnk_b, 0);
    check_output("b_vsync_768",   vsync_b, 0);
    apply_stimulus(47);
    check_output("b_vsync_770",   {vcount_b, 11'd0, vsync_b}, {12'd770, 12'd0});
    apply_stimulus(1);
    check_output("b_vsync_771",   vsync_b, 1);
    apply_stimulus(9);
    check_output("b_9_771",       {hcount_b, vcount_b, hsync_b}, {12'd9, 12'd771, 1'b0});

    en_b = 1'b0;
    apply_stimulus(7);
    check_output("b_frozen",       {hcount_b, vcount_b}, {12'd9, 12'd771});
    check_output("b_frozen_flags", {hsync_b, hblnk_b, vsync_b, vblnk_b}, 4'b0111);
    en_b = 1'b1;
    apply_stimulus(1);
    check_output("b_resume",       {hcount_b, vcount_b}, {12'd10, 12'd771});
    check_output("b_resume_flags", {hsync_b, vsync_b}, 2'b11);

    apply_stimulus(85);
    check_output("b_15_776",      {hcount_b, vcount_b, vsync_b}, {12'd15, 12'd776, 1'b1});
    apply_stimulus(1);
    check_output("b_vsync_777",   {vsync_b, vblnk_b}, 2'b01);
    apply_stimulus(463);
    check_output("b_15_805",      {hcount_b, vcount_b}, {12'd15, 12'd805});
    check_output("b_blanks_805",  {hblnk_b, vblnk_b}, 2'b11);
`ifdef VGA_FRAME_START_EN
    check_output("b_fs_before_wrap", fs_b, 0);
`endif
    apply_stimulus(1);
    check_output("b_frame_wrap",  {hcount_b, vcount_b}, 0);
    check_output("b_wrap_flags",  {hsync_b, hblnk_b, vsync_b, vblnk_b}, 0);
`ifdef VGA_FRAME_START_EN
    check_output("b_fs_pulse", fs_b, 1);
`endif
    apply_stimulus(1);
    check_output("b_after_wrap", {hcount_b, vcount_b}, {12'd1, 12'd0});
`ifdef VGA_FRAME_START_EN
    check_output("b_fs_one_cycle", fs_b, 0);
`endif

    cycles = 0;
    pulses = 0;
    do begin
      apply_stimulus(1);
      cycles++;
`ifdef VGA_FRAME_START_EN
      if (fs_b === 1'b1) pulses++;
`endif
    end while (!(hcount_b === 12'd0 && vcount_b === 12'd0) && cycles < 20000);
    check_output("b_frame_period", cycles + 1, 16 * 806);
`ifdef VGA_FRAME_START_EN
    check_output("b_fs_per_frame", pulses, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
